rv32_mod_fetch: RTL and testbench

//  Program-counter and instruction-fetch stage of the rv32imc core. It holds the PC and

---
 rtl/rv32_mod_fetch.sv | 131 +++++++++++++
 tb/tb_rv32_mod_fetch.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rv32_mod_fetch.sv
// PC and instruction-fetch stage: fetches one instruction over req/ack, holds it for
// execute, and computes the next PC (sequential, branch, or trap redirect) on retire.
module rv32_mod_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          C_EXT    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_is_compressed,
    input  logic        retire,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        trap_redirect,
    input  logic [31:0] trap_vector,
    output logic        fault_misaligned,
    output logic [31:0] fault_addr
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_c_q, instr_c_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_addr_q, fault_addr_d;

    logic        rdata_c;
    logic        target_misaligned;

    assign rdata_c           = C_EXT && (imem_rdata[1:0] != 2'b11);
    assign target_misaligned = C_EXT ? branch_target[0] : (branch_target[1:0] != 2'b00);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;
        instr_c_d    = instr_c_q;
        fault_d      = 1'b0;
        fault_addr_d = fault_addr_q;

        unique case (state_q)
            FETCH: begin
                // A redirect always wins over the response; if no ack has arrived yet the
                // outstanding one must be drained before the next request.
                if (trap_redirect) begin
                    pc_d    = trap_vector;
                    state_d = imem_ack ? FETCH : DRAIN;
                end else if (imem_ack) begin
                    instr_d    = rdata_c ? {16'h0000, imem_rdata[15:0]} : imem_rdata;
                    instr_pc_d = pc_q;
                    instr_c_d  = rdata_c;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (trap_redirect) begin
                    pc_d    = trap_vector;
                    state_d = FETCH;
                end else if (retire) begin
                    if (branch_taken && target_misaligned) begin
                        fault_d      = 1'b1;
                        fault_addr_d = branch_target;
                        state_d      = FAULT;
                    end else if (branch_taken) begin
                        pc_d    = branch_target;
                        state_d = FETCH;
                    end else begin
                        pc_d    = pc_q + (instr_c_q ? 32'd2 : 32'd4);
                        state_d = FETCH;
                    end
                end
            end
            DRAIN: begin
                if (trap_redirect) pc_d = trap_vector;
                if (imem_ack) state_d = FETCH;
            end
            FAULT: begin
                if (trap_redirect) begin
                    pc_d    = trap_vector;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            instr_q      <= '0;
            instr_pc_q   <= RESET_PC;
            instr_c_q    <= 1'b0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            instr_pc_q   <= instr_pc_d;
            instr_c_q    <= instr_c_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign imem_req            = (state_q == FETCH) && !rst;
    assign imem_addr           = pc_q;
    assign instr_valid         = (state_q == HOLD);
    assign instr               = instr_q;
    assign instr_pc            = instr_pc_q;
    assign instr_is_compressed = instr_c_q;
    assign fault_misaligned    = fault_q;
    assign fault_addr          = fault_addr_q;

endmodule

// File: tb/tb_rv32_mod_fetch.sv
// Directed bench for rv32_mod_fetch (RESET_PC=0x100, RVC enabled) with hand-computed
// expected PCs, instruction words and fault behaviour.
module tb_rv32_mod_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_is_compressed;
    logic        retire;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        trap_redirect;
    logic [31:0] trap_vector;
    logic        fault_misaligned;
    logic [31:0] fault_addr;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    rv32_mod_fetch #(
        .RESET_PC(32'h0000_0100),
        .C_EXT   (1'b1)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .imem_req           (imem_req),
        .imem_addr          (imem_addr),
        .imem_ack           (imem_ack),
        .imem_rdata         (imem_rdata),
        .instr_valid        (instr_valid),
        .instr              (instr),
        .instr_pc           (instr_pc),
        .instr_is_compressed(instr_is_compressed),
        .retire             (retire),
        .branch_taken       (branch_taken),
        .branch_target      (branch_target),
        .trap_redirect      (trap_redirect),
        .trap_vector        (trap_vector),
        .fault_misaligned   (fault_misaligned),
        .fault_addr         (fault_addr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expects a pending request at addr, returns rdata with zero wait, checks the held instr.
    task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] rdata,
                            input logic [31:0] exp_instr, input logic exp_c);
        chk({tag, ".req"}, {31'd0, imem_req}, 32'd1);
        chk({tag, ".addr"}, imem_addr, addr);
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        chk({tag, ".valid"}, {31'd0, instr_valid}, 32'd1);
        chk({tag, ".instr"}, instr, exp_instr);
        chk({tag, ".ipc"}, instr_pc, addr);
        chk({tag, ".c"}, {31'd0, instr_is_compressed}, {31'd0, exp_c});
    endtask

    // Retires with optional branch/trap and checks the following fetch address.
    task automatic do_retire(input string tag, input logic bt, input logic [31:0] tgt,
                             input logic tr, input logic [31:0] vec, input logic [31:0] exp_addr);
        retire        = 1'b1;
        branch_taken  = bt;
        branch_target = tgt;
        trap_redirect = tr;
        trap_vector   = vec;
        step();
        retire        = 1'b0;
        branch_taken  = 1'b0;
        trap_redirect = 1'b0;
        chk({tag, ".valid0"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, ".req"}, {31'd0, imem_req}, 32'd1);
        chk({tag, ".next"}, imem_addr, exp_addr);
    endtask

    initial begin
        rst           = 1'b1;
        imem_ack      = 1'b0;
        imem_rdata    = '0;
        retire        = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        trap_redirect = 1'b0;
        trap_vector   = '0;

        // reset
        step();
        chk("rst.req", {31'd0, imem_req}, 32'd0);
        chk("rst.valid", {31'd0, instr_valid}, 32'd0);
        chk("rst.instr", instr, 32'd0);
        chk("rst.ipc", instr_pc, 32'h100);
        chk("rst.fault", {31'd0, fault_misaligned}, 32'd0);
        chk("rst.faddr", fault_addr, 32'd0);
        step();
        rst = 1'b0;
        #1;

        // sequential: compressed (upper bits zeroed) then 32-bit
        do_fetch("c_li", 32'h100, 32'hABCD_4501, 32'h0000_4501, 1'b1);
        step();
        chk("hold.valid", {31'd0, instr_valid}, 32'd1);
        chk("hold.req", {31'd0, imem_req}, 32'd0);
        do_retire("seq2", 1'b0, 32'h0, 1'b0, 32'h0, 32'h102);
        do_fetch("addi", 32'h102, 32'h0000_0013, 32'h0000_0013, 1'b0);
        do_retire("seq4", 1'b0, 32'h0, 1'b0, 32'h0, 32'h106);

        // branches and PC wrap
        do_fetch("br1", 32'h106, 32'h0000_0013, 32'h0000_0013, 1'b0);
        do_retire("br1", 1'b1, 32'h200, 1'b0, 32'h0, 32'h200);
        do_fetch("br2", 32'h200, 32'h0000_0013, 32'h0000_0013, 1'b0);
        do_retire("br2", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'hFFFF_FFFC);
        do_fetch("wrap", 32'hFFFF_FFFC, 32'h0000_0013, 32'h0000_0013, 1'b0);
        do_retire("wrap", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0000_0000);

        // misaligned taken target
        do_fetch("mis", 32'h0, 32'h0000_0013, 32'h0000_0013, 1'b0);
        retire        = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h201;
        step();
        retire       = 1'b0;
        branch_taken = 1'b0;
        chk("mis.pulse", {31'd0, fault_misaligned}, 32'd1);
        chk("mis.faddr", fault_addr, 32'h201);
        chk("mis.req", {31'd0, imem_req}, 32'd0);
        chk("mis.valid", {31'd0, instr_valid}, 32'd0);
        step();
        chk("mis.pulse1", {31'd0, fault_misaligned}, 32'd0);
        step();
        step();
        chk("mis.noreq", {31'd0, imem_req}, 32'd0);
        trap_redirect = 1'b1;
        trap_vector   = 32'h80;
        step();
        trap_redirect = 1'b0;
        chk("mis.trap.req", {31'd0, imem_req}, 32'd1);
        chk("mis.trap.addr", imem_addr, 32'h80);

        // trap during a waited fetch: outstanding response discarded
        step();
        step();
        chk("wait.req", {31'd0, imem_req}, 32'd1);
        chk("wait.addr", imem_addr, 32'h80);
        trap_redirect = 1'b1;
        trap_vector   = 32'h400;
        step();
        trap_redirect = 1'b0;
        chk("drain.req", {31'd0, imem_req}, 32'd0);
        step();
        imem_ack   = 1'b1;
        imem_rdata = 32'h1111_1111;
        step();
        imem_ack = 1'b0;
        chk("drain.valid", {31'd0, instr_valid}, 32'd0);
        chk("drain.req1", {31'd0, imem_req}, 32'd1);
        do_fetch("postdrain", 32'h400, 32'h0000_0013, 32'h0000_0013, 1'b0);

        // trap without retire in HOLD drops the instruction
        trap_redirect = 1'b1;
        trap_vector   = 32'h600;
        step();
        trap_redirect = 1'b0;
        chk("drop.valid", {31'd0, instr_valid}, 32'd0);
        chk("drop.addr", imem_addr, 32'h600);

        // trap with ack in the same cycle
        imem_ack      = 1'b1;
        imem_rdata    = 32'h2222_2223;
        trap_redirect = 1'b1;
        trap_vector   = 32'h500;
        step();
        imem_ack      = 1'b0;
        trap_redirect = 1'b0;
        chk("track.valid", {31'd0, instr_valid}, 32'd0);
        chk("track.req", {31'd0, imem_req}, 32'd1);
        chk("track.addr", imem_addr, 32'h500);

        // trap beats branch on retire
        do_fetch("prio", 32'h500, 32'h0000_0013, 32'h0000_0013, 1'b0);
        do_retire("prio", 1'b1, 32'h200, 1'b1, 32'h80, 32'h80);

        // reset while holding
        do_fetch("rsth", 32'h80, 32'h0000_4501, 32'h0000_4501, 1'b1);
        rst = 1'b1;
        step();
        chk("rsth.valid", {31'd0, instr_valid}, 32'd0);
        chk("rsth.req", {31'd0, imem_req}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rsth.req1", {31'd0, imem_req}, 32'd1);
        chk("rsth.addr", imem_addr, 32'h100);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
